mem_stage: RTL and testbench

Memory pipeline stage between execute and writeback. Each cycle it registers one execute-stage entry and the synchronous data-memory read word that returns for it. It aligns and extends load data, and merges the two beats of a misaligned load into one result. It drives the forwarding and load-use signals that execute consumes (`mem_tgt_*`, `mem_result_out_*`, `is_load_mem`, `mem_bubble`, `mem_tgts_cr`).

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 58 +++++
 rtl/mem_stage_load_align.sv | 48 ++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, opcode size ranges, access-size and FSM types for the memory stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EXC_W  = 8;
  localparam int OPC_W  = 5;

  // Opcode ranges that select the memory access size
  localparam logic [OPC_W-1:0] OPC_WORD_LO = 5'd3;
  localparam logic [OPC_W-1:0] OPC_WORD_HI = 5'd5;
  localparam logic [OPC_W-1:0] OPC_DBL_LO  = 5'd6;
  localparam logic [OPC_W-1:0] OPC_DBL_HI  = 5'd8;
  localparam logic [OPC_W-1:0] OPC_BYTE_LO = 5'd9;
  localparam logic [OPC_W-1:0] OPC_BYTE_HI = 5'd11;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,  // 4 bytes
    SZ_D = 2'd1,  // 2 bytes
    SZ_B = 2'd2   // 1 byte
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,  // no partial load/store outstanding
    HALF = 1'b1   // first beat of a misaligned access seen, waiting for the second
  } state_e;

  // Non-memory opcodes fall back to word size; their size is never used for data.
  function automatic size_e decode_size(input logic [OPC_W-1:0] opc);
    size_e sz;
    sz = SZ_W;
    if (opc >= OPC_WORD_LO && opc <= OPC_WORD_HI) begin
      sz = SZ_W;
    end else if (opc >= OPC_DBL_LO && opc <= OPC_DBL_HI) begin
      sz = SZ_D;
    end else if (opc >= OPC_BYTE_LO && opc <= OPC_BYTE_HI) begin
      sz = SZ_B;
    end
    return sz;
  endfunction

  // True when an access of this size at this offset spills into the next word.
  function automatic logic crosses_word(input size_e sz, input logic [1:0] off);
    return ((sz == SZ_W) && (off != 2'd0)) || ((sz == SZ_D) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-entry, flush and forwarding signals between execute and the memory stage.
// Latency: n/a (wires only).
// Backpressure: none carried; clk_en/halt are the only stall and drain controls.
interface mem_stage_if;
  import mem_stage_pkg::*;

  // control
  logic              clk_en;
  logic              halt;
  // execute entry
  logic              bubble_in;
  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  tgt_1;
  logic [REG_W-1:0]  tgt_2;
  logic [DATA_W-1:0] result_1;
  logic [DATA_W-1:0] result_2;
  logic [DATA_W-1:0] addr;
  logic              is_load;
  logic              is_store;
  logic              was_misaligned;
  logic              tgts_cr;
  logic [EXC_W-1:0]  exc_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] rdata;
  // flush requests from writeback
  logic              exc_in_wb;
  logic              rfe_in_wb;
  // registered stage outputs
  logic [DATA_W-1:0] mem_result_out_1;
  logic [DATA_W-1:0] mem_result_out_2;
  logic [REG_W-1:0]  mem_tgt_1;
  logic [REG_W-1:0]  mem_tgt_2;
  logic              mem_bubble;
  logic              is_load_mem;
  logic              mem_tgts_cr;
  logic [EXC_W-1:0]  exc_out;
  logic [DATA_W-1:0] pc_out;
  logic [OPC_W-1:0]  opcode_out;

  // execute side: drives the entry, consumes the forwarding outputs
  modport master (
    output clk_en, halt, bubble_in, opcode, tgt_1, tgt_2, result_1, result_2, addr,
           is_load, is_store, was_misaligned, tgts_cr, exc_in, pc_in, rdata,
           exc_in_wb, rfe_in_wb,
    input  mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2, mem_bubble,
           is_load_mem, mem_tgts_cr, exc_out, pc_out, opcode_out
  );

  // memory stage side
  modport slave (
    input  clk_en, halt, bubble_in, opcode, tgt_1, tgt_2, result_1, result_2, addr,
           is_load, is_store, was_misaligned, tgts_cr, exc_in, pc_in, rdata,
           exc_in_wb, rfe_in_wb,
    output mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2, mem_bubble,
           is_load_mem, mem_tgts_cr, exc_out, pc_out, opcode_out
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: extracts, shifts, merges and extends load data from the memory read word (option: LOAD_SIGN_EXT_EN).
// Latency: combinational.
// Backpressure: none.
module load_align
  import mem_stage_pkg::*;
(
  input  size_e             size_i,
  input  logic [1:0]        off_i,     // current offset on beat 0 / aligned, latched offset on beat 1
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] part_i,    // low bytes captured on the first beat
  input  logic              second_i,  // merge part_i with the next word's low bytes
  output logic [DATA_W-1:0] shifted_o, // rdata moved down by the byte offset; also the part to capture
  output logic [DATA_W-1:0] data_o
);

`ifdef LOAD_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  logic [4:0]        sh_down;
  logic [5:0]        sh_up;
  logic [DATA_W-1:0] raw;

  assign sh_down   = {off_i, 3'b000};
  // Bytes still missing from beat 1 sit at the bottom of rdata and move up past the captured ones.
  assign sh_up     = 6'd32 - {1'b0, off_i, 3'b000};
  assign shifted_o = rdata_i >> sh_down;

  // Select the raw little-endian value, then extend it to the access size
  always_comb begin
    raw = shifted_o;
    if (second_i) begin
      case (size_i)
        SZ_W:    raw = part_i | (rdata_i << sh_up);
        SZ_D:    raw = {16'h0000, rdata_i[7:0], part_i[7:0]};
        default: raw = shifted_o;
      endcase
    end
    case (size_i)
      SZ_B:    data_o = {{24{SIGN_EXT & raw[7]}}, raw[7:0]};
      SZ_D:    data_o = {{16{SIGN_EXT & raw[15]}}, raw[15:0]};
      default: data_o = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: registers one execute entry per cycle, aligns/extends load data, merges misaligned two-beat loads (option: LOAD_SIGN_EXT_EN).
// Latency: 1 cycle entry to outputs; a misaligned access emits a bubble for beat 0 and its result one cycle after beat 1.
// Backpressure: none; clk_en low freezes all state, halt and flush force bubble outputs and drop any partial merge.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave mem_if
);

  size_e             size_w;
  logic [1:0]        off_w;
  logic [1:0]        align_off_w;
  logic              mem_acc_w;
  logic              has_exc_w;
  logic              flush_w;
  logic              first_beat_w;
  logic              second_beat_w;
  logic              orphan_w;
  logic              merge_w;
  logic [DATA_W-1:0] shifted_w;
  logic [DATA_W-1:0] load_data_w;
  logic              unused_addr_w;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] part_q, part_d;
  logic [1:0]        off_q, off_d;
  logic              bubble_q, bubble_d;
  logic [DATA_W-1:0] res1_q, res1_d;
  logic [DATA_W-1:0] res2_q, res2_d;
  logic [REG_W-1:0]  tgt1_q, tgt1_d;
  logic [REG_W-1:0]  tgt2_q, tgt2_d;
  logic              ld_q, ld_d;
  logic              cr_q, cr_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [OPC_W-1:0]  opc_q, opc_d;

  assign size_w        = decode_size(mem_if.opcode);
  assign off_w         = mem_if.addr[1:0];
  assign unused_addr_w = ^mem_if.addr[DATA_W-1:2];

  assign mem_acc_w = (mem_if.is_load || mem_if.is_store) && !mem_if.bubble_in;
  assign has_exc_w = (mem_if.exc_in != '0);
  assign flush_w   = mem_if.exc_in_wb || mem_if.rfe_in_wb;

  // A faulting access is reported on its own beat rather than split into two.
  assign first_beat_w  = mem_acc_w && !mem_if.was_misaligned && !has_exc_w &&
                         crosses_word(size_w, off_w);
  assign second_beat_w = !mem_if.bubble_in && mem_if.was_misaligned && (state_q == HALF);
  assign orphan_w      = !mem_if.bubble_in && mem_if.was_misaligned && (state_q == IDLE);
  assign merge_w       = second_beat_w && mem_if.is_load;
  assign align_off_w   = merge_w ? off_q : off_w;

  load_align u_load_align (
    .size_i    (size_w),
    .off_i     (align_off_w),
    .rdata_i   (mem_if.rdata),
    .part_i    (part_q),
    .second_i  (merge_w),
    .shifted_o (shifted_w),
    .data_o    (load_data_w)
  );

  // FSM state register; clk_en low freezes a merge in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (mem_if.clk_en) begin
      state_q <= state_d;
    end
  end

  // Next state: any real entry other than a first beat ends a pending merge; bubbles keep it
  always_comb begin
    state_d = state_q;
    if (mem_if.halt || flush_w) begin
      state_d = IDLE;
    end else if (!mem_if.bubble_in) begin
      state_d = first_beat_w ? HALF : IDLE;
    end
  end

  // Next values of the stage outputs and the merge buffer
  always_comb begin
    bubble_d = 1'b1;
    tgt1_d   = '0;
    tgt2_d   = '0;
    ld_d     = 1'b0;
    cr_d     = 1'b0;
    exc_d    = '0;
    res1_d   = mem_if.is_load ? load_data_w : mem_if.result_1;
    res2_d   = mem_if.result_2;
    pc_d     = mem_if.pc_in;
    opc_d    = mem_if.opcode;
    part_d   = part_q;
    off_d    = off_q;
    if (mem_if.halt || flush_w) begin
      part_d = '0;
      off_d  = '0;
    end else if (mem_if.bubble_in || orphan_w) begin
      // emitted as a bubble; a pending merge survives plain bubbles
    end else if (first_beat_w) begin
      ld_d   = mem_if.is_load;
      part_d = shifted_w;
      off_d  = off_w;
    end else begin
      bubble_d = 1'b0;
      ld_d     = mem_if.is_load;
      exc_d    = mem_if.exc_in;
      if (!has_exc_w) begin
        tgt1_d = mem_if.tgt_1;
        tgt2_d = mem_if.tgt_2;
        cr_d   = mem_if.tgts_cr;
      end
    end
  end

  // Pipeline output registers and merge buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= 1'b1;
      res1_q   <= '0;
      res2_q   <= '0;
      tgt1_q   <= '0;
      tgt2_q   <= '0;
      ld_q     <= 1'b0;
      cr_q     <= 1'b0;
      exc_q    <= '0;
      pc_q     <= '0;
      opc_q    <= '0;
      part_q   <= '0;
      off_q    <= '0;
    end else if (mem_if.clk_en) begin
      bubble_q <= bubble_d;
      res1_q   <= res1_d;
      res2_q   <= res2_d;
      tgt1_q   <= tgt1_d;
      tgt2_q   <= tgt2_d;
      ld_q     <= ld_d;
      cr_q     <= cr_d;
      exc_q    <= exc_d;
      pc_q     <= pc_d;
      opc_q    <= opc_d;
      part_q   <= part_d;
      off_q    <= off_d;
    end
  end

  assign mem_if.mem_bubble       = bubble_q;
  assign mem_if.mem_result_out_1 = res1_q;
  assign mem_if.mem_result_out_2 = res2_q;
  assign mem_if.mem_tgt_1        = tgt1_q;
  assign mem_if.mem_tgt_2        = tgt2_q;
  assign mem_if.is_load_mem      = ld_q;
  assign mem_if.mem_tgts_cr      = cr_q;
  assign mem_if.exc_out          = exc_q;
  assign mem_if.pc_out           = pc_q;
  assign mem_if.opcode_out       = opc_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

`ifdef LOAD_SIGN_EXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   nchk  = 0;
  int   npass = 0;
  logic [31:0] pc_ctr = 32'h0000_0400;

  mem_stage_if m ();

  mem_stage dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (m)
  );

  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %08h required %08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  function automatic int nbytes(input logic [4:0] opc);
    if (opc >= 5'd6 && opc <= 5'd8) return 2;
    if (opc >= 5'd9 && opc <= 5'd11) return 1;
    return 4;
  endfunction

  // ---------------- behavioural model (byte-level) ----------------
  logic        e_bub, e_ld, e_cr;
  logic [4:0]  e_t1, e_t2, e_opc;
  logic [7:0]  e_exc;
  logic [31:0] e_r1, e_r2, e_pc;
  logic [7:0]  pend[$];
  bit          merging;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0]  got[$];
    int          n;
    int          off;
    logic [31:0] v;
    if (!rst_n) begin
      e_bub = 1; e_ld = 0; e_cr = 0; e_t1 = 0; e_t2 = 0; e_opc = 0;
      e_exc = 0; e_r1 = 0; e_r2 = 0; e_pc = 0;
      pend.delete(); merging = 0;
    end else if (m.clk_en) begin
      e_pc = m.pc_in; e_opc = m.opcode; e_r1 = m.result_1; e_r2 = m.result_2;
      e_bub = 1; e_ld = 0; e_cr = 0; e_t1 = 0; e_t2 = 0; e_exc = 0;
      n   = nbytes(m.opcode);
      off = int'(m.addr[1:0]);
      if (m.halt || m.exc_in_wb || m.rfe_in_wb) begin
        pend.delete(); merging = 0;
      end else if (m.bubble_in) begin
        // nothing emitted, pending bytes kept
      end else if (m.was_misaligned && !merging) begin
        // second beat with no first beat: dropped as a bubble
      end else if ((m.is_load || m.is_store) && !m.was_misaligned && m.exc_in == 0 && off + n > 4) begin
        pend.delete();
        for (int i = off; i < 4; i++) pend.push_back(byte_of(m.rdata, i));
        merging = 1;
        e_ld = m.is_load;
      end else begin
        got.delete();
        if (m.was_misaligned) begin
          got = pend;
          for (int i = 0; got.size() < n; i++) got.push_back(byte_of(m.rdata, i));
        end else if (m.is_load) begin
          for (int i = 0; i < n; i++) got.push_back(byte_of(m.rdata, (off + i) % 4));
        end
        v = 0;
        if (m.is_load) begin
          for (int i = 0; i < n; i++) v = v | (32'(got[i]) << (8 * i));
          if (SEXT && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
          if (SEXT && n == 2 && v[15]) v = v | 32'hFFFF_0000;
          e_r1 = v;
        end
        pend.delete(); merging = 0;
        e_bub = 0; e_ld = m.is_load; e_exc = m.exc_in;
        if (m.exc_in == 0) begin
          e_t1 = m.tgt_1; e_t2 = m.tgt_2; e_cr = m.tgts_cr;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("bubble", 32'(m.mem_bubble), 32'(e_bub));
    check("tgt_1", 32'(m.mem_tgt_1), 32'(e_t1));
    check("tgt_2", 32'(m.mem_tgt_2), 32'(e_t2));
    check("is_load_mem", 32'(m.is_load_mem), 32'(e_ld));
    check("tgts_cr", 32'(m.mem_tgts_cr), 32'(e_cr));
    check("exc_out", 32'(m.exc_out), 32'(e_exc));
    if (!e_bub) begin
      check("result_1", m.mem_result_out_1, e_r1);
      check("result_2", m.mem_result_out_2, e_r2);
      check("pc_out", m.pc_out, e_pc);
      check("opcode_out", 32'(m.opcode_out), 32'(e_opc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    m.clk_en = 1; m.halt = 0; m.bubble_in = 1; m.opcode = 0; m.tgt_1 = 0; m.tgt_2 = 0;
    m.result_1 = 0; m.result_2 = 0; m.addr = 0; m.is_load = 0; m.is_store = 0;
    m.was_misaligned = 0; m.tgts_cr = 0; m.exc_in = 0; m.pc_in = 0; m.rdata = 0;
    m.exc_in_wb = 0; m.rfe_in_wb = 0;
  endtask

  task automatic set_entry(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] rd,
                           input logic ld, input logic st, input logic wm,
                           input logic [4:0] t1, input logic [7:0] exc);
    set_idle();
    m.bubble_in = 0; m.opcode = opc; m.addr = a; m.rdata = rd;
    m.is_load = ld; m.is_store = st; m.was_misaligned = wm;
    m.tgt_1 = t1; m.tgt_2 = t1 + 5'd1; m.exc_in = exc;
    m.result_1 = a ^ 32'h5A5A_0000; m.result_2 = a + 32'd4;
    m.pc_in = pc_ctr; pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bubble"}, 32'(m.mem_bubble), 32'd1);
    check({tag, "_res1"}, m.mem_result_out_1, 32'd0);
    check({tag, "_res2"}, m.mem_result_out_2, 32'd0);
    check({tag, "_tgt1"}, 32'(m.mem_tgt_1), 32'd0);
    check({tag, "_isld"}, 32'(m.is_load_mem), 32'd0);
    check({tag, "_exc"}, 32'(m.exc_out), 32'd0);
    check({tag, "_pc"}, m.pc_out, 32'd0);
    check({tag, "_opc"}, 32'(m.opcode_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    rst_n = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // aligned word load
    set_entry(5'd3, 32'h1000, 32'hDEAD_BEEF, 1, 0, 0, 5'd5, 8'h00); step();
    check("ld_word_data", m.mem_result_out_1, 32'hDEAD_BEEF);
    check("ld_word_tgt", 32'(m.mem_tgt_1), 32'd5);
    check("ld_word_isld", 32'(m.is_load_mem), 32'd1);

    // byte loads, including the sign bit at the top byte
    set_entry(5'd9, 32'h1002, 32'h1122_3344, 1, 0, 0, 5'd6, 8'h00); step();
    check("ld_byte_off2", m.mem_result_out_1, 32'h0000_0022);
    set_entry(5'd10, 32'h1003, 32'h8000_0000, 1, 0, 0, 5'd6, 8'h00); step();
    check("ld_byte_ext", m.mem_result_out_1, SEXT ? 32'hFFFF_FF80 : 32'h0000_0080);

    // aligned doubleword at offset 2 with bit 15 set
    set_entry(5'd7, 32'h1002, 32'h80FF_1234, 1, 0, 0, 5'd4, 8'h00); step();
    check("ld_dbl_ext", m.mem_result_out_1, SEXT ? 32'hFFFF_80FF : 32'h0000_80FF);

    // non-memory op passes results and control-register flag through
    set_entry(5'd1, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 5'd10, 8'h00);
    m.result_1 = 32'hCAFE_F00D; m.tgts_cr = 1; step();
    check("alu_res1", m.mem_result_out_1, 32'hCAFE_F00D);
    check("alu_cr", 32'(m.mem_tgts_cr), 32'd1);

    // misaligned word load at offset 1
    set_entry(5'd3, 32'h1001, 32'hAABB_CCDD, 1, 0, 0, 5'd8, 8'h00); step();
    check("mis_w_b0_bubble", 32'(m.mem_bubble), 32'd1);
    check("mis_w_b0_tgt", 32'(m.mem_tgt_1), 32'd0);
    check("mis_w_b0_isld", 32'(m.is_load_mem), 32'd1);
    set_entry(5'd3, 32'h1004, 32'h1122_3344, 1, 0, 1, 5'd8, 8'h00); step();
    check("mis_w_data", m.mem_result_out_1, 32'h44AA_BBCC);
    check("mis_w_tgt", 32'(m.mem_tgt_1), 32'd8);

    // misaligned doubleword load at offset 3
    set_entry(5'd6, 32'h1003, 32'hAABB_CCDD, 1, 0, 0, 5'd11, 8'h00); step();
    set_entry(5'd6, 32'h1004, 32'h1122_3344, 1, 0, 1, 5'd11, 8'h00); step();
    check("mis_d_data", m.mem_result_out_1, 32'h0000_44AA);

    // misaligned word at offset 2 with a bubble and a stall between the beats
    set_entry(5'd4, 32'h1002, 32'h5566_7788, 1, 0, 0, 5'd12, 8'h00); step();
    set_idle(); step();
    set_entry(5'd4, 32'h1004, 32'h0BAD_0BAD, 1, 0, 1, 5'd12, 8'h00);
    m.clk_en = 0; step(); step();
    check("stall_hold_bubble", 32'(m.mem_bubble), 32'd1);
    set_entry(5'd4, 32'h1004, 32'h99AA_BBCC, 1, 0, 1, 5'd12, 8'h00); step();
    check("mis_stall_data", m.mem_result_out_1, 32'hBBCC_5566);

    // writeback flush between the beats, then a fresh aligned load and an orphan beat
    set_entry(5'd3, 32'h1001, 32'hAABB_CCDD, 1, 0, 0, 5'd13, 8'h00); step();
    set_entry(5'd3, 32'h1004, 32'h1122_3344, 1, 0, 1, 5'd13, 8'h00);
    m.exc_in_wb = 1; step();
    check("flush_bubble", 32'(m.mem_bubble), 32'd1);
    check("flush_exc", 32'(m.exc_out), 32'd0);
    set_entry(5'd3, 32'h2000, 32'h1234_5678, 1, 0, 0, 5'd9, 8'h00); step();
    check("post_flush_data", m.mem_result_out_1, 32'h1234_5678);
    check("post_flush_tgt", 32'(m.mem_tgt_1), 32'd9);
    set_entry(5'd3, 32'h2004, 32'hFFFF_FFFF, 1, 0, 1, 5'd9, 8'h00); step();
    check("orphan_bubble", 32'(m.mem_bubble), 32'd1);

    // exception on a load kills its targets
    set_entry(5'd3, 32'h3000, 32'h0102_0304, 1, 0, 0, 5'd7, 8'h02); step();
    check("exc_code", 32'(m.exc_out), 32'h02);
    check("exc_tgt", 32'(m.mem_tgt_1), 32'd0);
    check("exc_not_bubble", 32'(m.mem_bubble), 32'd0);

    // return-from-exception flush between doubleword beats
    set_entry(5'd7, 32'h1003, 32'h7700_0000, 1, 0, 0, 5'd14, 8'h00); step();
    set_idle(); m.rfe_in_wb = 1; step();
    set_entry(5'd7, 32'h1004, 32'h0000_0066, 1, 0, 1, 5'd14, 8'h00); step();
    check("rfe_orphan_bubble", 32'(m.mem_bubble), 32'd1);

    // halt mid-merge drains and clears the partial
    set_entry(5'd3, 32'h1003, 32'hAABB_CCDD, 1, 0, 0, 5'd15, 8'h00); step();
    set_entry(5'd1, 32'h0, 32'h0, 0, 0, 0, 5'd3, 8'h00); m.halt = 1; step();
    check("halt_bubble", 32'(m.mem_bubble), 32'd1);
    set_entry(5'd3, 32'h1004, 32'h1122_3344, 1, 0, 1, 5'd15, 8'h00); step();
    check("halt_orphan_bubble", 32'(m.mem_bubble), 32'd1);

    // misaligned store: bubble then pass-through
    set_entry(5'd3, 32'h1002, 32'h0, 0, 1, 0, 5'd0, 8'h00); step();
    check("st_b0_bubble", 32'(m.mem_bubble), 32'd1);
    check("st_b0_isld", 32'(m.is_load_mem), 32'd0);
    set_entry(5'd3, 32'h1004, 32'h0, 0, 1, 1, 5'd0, 8'h00); step();
    check("st_b1_bubble", 32'(m.mem_bubble), 32'd0);
    check("st_b1_res1", m.mem_result_out_1, 32'h5A5A_1004);

    // asynchronous reset mid-merge discards the partial
    set_entry(5'd3, 32'h1001, 32'hAABB_CCDD, 1, 0, 0, 5'd16, 8'h00); step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    step();
    set_entry(5'd3, 32'h1004, 32'h1122_3344, 1, 0, 1, 5'd16, 8'h00);
    rst_n = 1'b1; step();
    check("rst_orphan_bubble", 32'(m.mem_bubble), 32'd1);

    set_idle(); step(); step();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
